// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state encoding and ROM word field offsets for the LED frame sequencer
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PAT_LSB = 0;
    localparam int END_BIT = 32;
    localparam int BRT_LSB = 33;
    localparam int BRT_W   = 3;

endpackage

// File: rtl/led_pwm_gate.sv
// led_pwm_gate: gates the 32-bit pattern with a free-running 3-bit PWM counter
//   clk, rst_n  : clock, asynchronous active-low reset
//   pattern     : captured 32-bit LED pattern
//   brightness  : captured brightness, duty = (brightness+1)/8
//   leds        : gated pattern (pattern while pwm_cnt <= brightness, else 0)
module led_pwm_gate
    import led_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pattern,
    input  logic [BRT_W-1:0] brightness,
    output logic [31:0]      leds
);

    logic [BRT_W-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 1'b1;

    assign leds = (pwm_cnt <= brightness) ? pattern : '0;

endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: steps through the pattern ROM one frame at a time and drives four LED banks
//   clk, rst_n     : clock, asynchronous active-low reset
//   run            : 1 = sequence, 0 = pause (frame restarts on resume)
//   rom_addr       : ROM read address
//   rom_data       : ROM word, [31:0] pattern, [32] end flag, [35:33] brightness
//   bank0..bank3   : pattern bytes 0..3
//   frame_strobe   : one-cycle pulse when the banks take a new pattern
//   wrap           : one-cycle pulse when rom_addr returns to 0
// Optional feature: define LED_PWM_EN to gate the banks with per-pattern brightness PWM.
// ROM_LAT counts capture edges after the address edge: rom_data is sampled on the
// ROM_LAT-th rising edge after rom_addr changes.
module led_frame_sequencer
    import led_seq_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 36,
    parameter int ROM_LAT     = 1,
    parameter int FRAME_TICKS = 1024,
    parameter int LAST_ADDR   = 127
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [7:0]        bank0,
    output logic [7:0]        bank1,
    output logic [7:0]        bank2,
    output logic [7:0]        bank3,
    output logic              frame_strobe,
    output logic              wrap
);

    localparam int LAT_W  = ROM_LAT > 1 ? $clog2(ROM_LAT) : 1;
    localparam int TICK_W = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [31:0]       pattern;
    logic              end_flag;
    logic [31:0]       leds;
    logic              last_fetch;
    logic              last_tick;
    logic              to_zero;

    assign last_fetch = lat_cnt == LAT_W'(ROM_LAT - 1);
    assign last_tick  = tick_cnt == TICK_W'(FRAME_TICKS - 1);
    assign to_zero    = end_flag || rom_addr == ADDR_W'(LAST_ADDR);

`ifdef LED_PWM_EN
    logic [BRT_W-1:0] brightness;

    led_pwm_gate u_gate (
        .clk        (clk),
        .rst_n      (rst_n),
        .pattern    (pattern),
        .brightness (brightness),
        .leds       (leds)
    );
`else
    logic unused_bits;
    assign unused_bits = ^rom_data[DATA_W-1:END_BIT+1];
    assign leds        = pattern;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            tick_cnt     <= '0;
            rom_addr     <= '0;
            pattern      <= '0;
            end_flag     <= 1'b0;
            frame_strobe <= 1'b0;
            wrap         <= 1'b0;
`ifdef LED_PWM_EN
            brightness   <= '0;
`endif
        end else begin
            frame_strobe <= 1'b0;
            wrap         <= 1'b0;
            case (state)
                IDLE: begin
                    lat_cnt  <= '0;
                    tick_cnt <= '0;
                    if (run) state <= FETCH;
                end
                FETCH: begin
                    if (!run) begin
                        state   <= IDLE;
                        lat_cnt <= '0;
                    end else if (last_fetch) begin
                        pattern      <= rom_data[PAT_LSB +: 32];
                        end_flag     <= rom_data[END_BIT];
`ifdef LED_PWM_EN
                        brightness   <= rom_data[BRT_LSB +: BRT_W];
`endif
                        frame_strobe <= 1'b1;
                        lat_cnt      <= '0;
                        tick_cnt     <= '0;
                        state        <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // A frame that completes still advances even if run drops on that edge.
                    if (last_tick) begin
                        rom_addr <= to_zero ? '0 : rom_addr + 1'b1;
                        wrap     <= to_zero;
                        tick_cnt <= '0;
                        state    <= run ? FETCH : IDLE;
                    end else if (!run) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bank0 = leds[7:0];
    assign bank1 = leds[15:8];
    assign bank2 = leds[23:16];
    assign bank3 = leds[31:24];

endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb_led_frame_sequencer: randomized scoreboard bench for led_frame_sequencer
module tb_led_frame_sequencer;

    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 36;
    localparam int ROM_LAT     = 1;
    localparam int FRAME_TICKS = 4;
    localparam int LAST_ADDR   = 3;
    localparam int PERIOD      = ROM_LAT + FRAME_TICKS;

    typedef struct {
        int                cyc;
        bit                is_wrap;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       pat;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              run = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [7:0]        bank0, bank1, bank2, bank3;
    logic              frame_strobe, wrap;

    logic [DATA_W-1:0] rom_img [2**ADDR_W];
    ev_t               exp_q [$];
    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;

    // reference model: frame position counted in cycles since the frame began
    logic [ADDR_W-1:0] m_addr = '0;
    bit                m_active = 1'b0;
    int                m_pos = 0;
    logic [31:0]       m_show = '0;
    logic [2:0]        m_brt = '0;
    logic [2:0]        m_pwm = '0;
    bit                m_z;

    ev_t               mon_e;
    logic [31:0]       mon_banks;

    always #5 clk = ~clk;

    assign rom_data = rom_img[rom_addr];

    led_frame_sequencer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ROM_LAT     (ROM_LAT),
        .FRAME_TICKS (FRAME_TICKS),
        .LAST_ADDR   (LAST_ADDR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .bank0        (bank0),
        .bank1        (bank1),
        .bank2        (bank2),
        .bank3        (bank3),
        .frame_strobe (frame_strobe),
        .wrap         (wrap)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_addr   = '0;
            m_active = 1'b0;
            m_pos    = 0;
            m_show   = '0;
            m_brt    = '0;
            m_pwm    = '0;
            exp_q.delete();
        end else begin
            cyc++;
            m_pwm++;
            if (!m_active) begin
                m_active = run;
                m_pos    = 0;
            end else if (m_pos == PERIOD - 1) begin
                m_z    = rom_img[m_addr][32] || m_addr == LAST_ADDR;
                m_addr = m_z ? '0 : m_addr + 1'b1;
                if (m_z) exp_q.push_back('{cyc, 1'b1, '0, '0});
                m_pos    = 0;
                m_active = run;
            end else if (!run) begin
                m_active = 1'b0;
            end else begin
                m_pos++;
                if (m_pos == ROM_LAT) begin
                    m_show = rom_img[m_addr][31:0];
                    m_brt  = rom_img[m_addr][35:33];
                    exp_q.push_back('{cyc, 1'b0, m_addr, m_show});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            mon_banks = m_show;
`ifdef LED_PWM_EN
            if (m_pwm > m_brt) mon_banks = '0;
`endif
            check("rom_addr", rom_addr, m_addr);
            check("banks", {bank3, bank2, bank1, bank0}, mon_banks);
            if (frame_strobe || wrap) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {frame_strobe, wrap}, 2'b00);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_cycle", cyc, mon_e.cyc);
                    check("pulse_kind", {frame_strobe, wrap}, mon_e.is_wrap ? 2'b01 : 2'b10);
                    if (!mon_e.is_wrap) check("strobe_addr", rom_addr, mon_e.addr);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                check("missed_pulse", {frame_strobe, wrap}, mon_e.is_wrap ? 2'b01 : 2'b10);
            end
        end
    end

    task automatic wait_strobe(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_strobe) return;
        end
        check("strobe_timeout", 0, 1);
    endtask

    task automatic wait_pos(input int a, input int p, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_active && m_addr == a && m_pos == p) return;
        end
        check("position_timeout", 0, 1);
    endtask

    task automatic pause_idle();
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        check("rst_rom_addr", rom_addr, 0);
        check("rst_banks", {bank3, bank2, bank1, bank0}, 0);
        check("rst_pulses", {frame_strobe, wrap}, 0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, w, last, cnt;
        for (int i = 0; i < 2**ADDR_W; i++) rom_img[i] = '0;
        rom_img[0] = 36'hE_04030201;
        for (int i = 1; i <= LAST_ADDR; i++) rom_img[i] = {3'b111, 1'b0, 32'($urandom)};
        repeat (3) @(negedge clk);
        check("reset_rom_addr", rom_addr, 0);
        check("reset_banks", {bank3, bank2, bank1, bank0}, 0);
        check("reset_pulses", {frame_strobe, wrap}, 0);
        rst_n = 1'b1;

        @(negedge clk);
        run = 1'b1;
        t0  = cyc;
        wait_strobe(20);
        check("first_latency", cyc - t0, ROM_LAT + 1);
        check("first_banks", {bank3, bank2, bank1, bank0}, 32'h04030201);
        repeat (FRAME_TICKS) @(negedge clk);
        check("addr_after_frame", rom_addr, 1);

        w    = 0;
        last = -1;
        for (int i = 0; i < 20; i++) begin
            if (wrap) w++;
            if (frame_strobe) begin
                if (last >= 0) check("strobe_spacing", cyc - last, PERIOD);
                last = cyc;
            end
            @(negedge clk);
        end
        check("wrap_count", w, 1);

        pause_idle();
        rom_img[1][32] = 1'b1;
        run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rom_addr == 2) cnt++;
        end
        check("addr2_skipped", cnt, 0);

        pause_idle();
        rom_img[1][32] = 1'b0;
        run = 1'b1;
        wait_pos(2, ROM_LAT + 1, 60);
        run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_strobe) cnt++;
        end
        check("paused_strobes", cnt, 0);
        check("paused_banks", {bank3, bank2, bank1, bank0}, rom_img[2][31:0]);
        check("paused_addr", rom_addr, 2);
        run = 1'b1;
        t0  = cyc;
        wait_strobe(20);
        check("resume_latency", cyc - t0, 2);
        check("resume_addr", rom_addr, 2);

        wait_pos(3, 0, 40);
        reset_pulse();
        wait_strobe(20);
        check("restart_addr", rom_addr, 0);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            run = $urandom_range(0, 7) != 0;
            if (!m_active && $urandom_range(0, 2) == 0)
                rom_img[$urandom_range(0, LAST_ADDR)] =
                    {3'($urandom), $urandom_range(0, 3) == 0, 32'($urandom)};
            if ($urandom_range(0, 99) == 0) reset_pulse();
        end

`ifdef LED_PWM_EN
        pause_idle();
        rom_img[0] = 36'h7_FFFFFFFF;
        reset_pulse();
        run = 1'b1;
        wait_strobe(20);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bank0 == 8'hFF) cnt++;
        end
        check("pwm_duty_b3", cnt, 20);
        pause_idle();
        rom_img[0] = 36'h1_FFFFFFFF;
        run = 1'b1;
        wait_strobe(20);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bank0 == 8'hFF) cnt++;
        end
        check("pwm_duty_b0", cnt, 5);
`endif

        pause_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
